// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - handshake bundle for imm_gen_pipe: instruction in, immediate out
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [24:0]      in_inst;
  logic [2:0]       in_sel;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  modport master (
    output in_valid, in_inst, in_sel, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_inst, in_sel, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_illegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered RV32I/RV64I immediate generator with 2-entry skid FIFO
// Define IMM_ZIMM_EN to decode select 110 as the CSR uimm (zext of inst[19:15]).
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input logic          clk,
  input logic          rst,
  imm_gen_pipe_if.slave bus
);
  logic [31:7]      b;
  logic [31:0]      raw;
  logic             use_sext;
  logic             ill_c;
  logic [XLEN-1:0]  imm_c;

  assign b = bus.in_inst;

  always_comb begin
    raw      = '0;
    use_sext = 1'b0;
    ill_c    = 1'b0;
    case (bus.in_sel)
      3'd0: begin use_sext = 1'b1; raw = {{20{b[31]}}, b[31:20]}; end
      3'd1: begin use_sext = 1'b1; raw = {{20{b[31]}}, b[31:25], b[11:7]}; end
      3'd2: begin use_sext = 1'b1; raw = {{19{b[31]}}, b[31], b[7], b[30:25], b[11:8], 1'b0}; end
      3'd3: begin use_sext = 1'b1; raw = {{11{b[31]}}, b[31], b[19:12], b[20], b[30:21], 1'b0}; end
      3'd4: begin use_sext = 1'b1; raw = {b[31:12], 12'b0}; end
      3'd5: raw = (XLEN == 32) ? {27'b0, b[24:20]} : {26'b0, b[25:20]};
`ifdef IMM_ZIMM_EN
      3'd6: raw = {27'b0, b[19:15]};
`else
      3'd6: ill_c = 1'b1;
`endif
      default: ill_c = 1'b1;
    endcase
    // raw is already a 32-bit two's-complement value; the cast widens it to XLEN
    if (use_sext) imm_c = XLEN'($signed(raw));
    else          imm_c = XLEN'(raw);
  end

  logic [XLEN-1:0]  mem_imm [2];
  logic [TAG_W-1:0] mem_tag [2];
  logic             mem_ill [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic [XLEN-1:0]  last_imm;
  logic [TAG_W-1:0] last_tag;
  logic             last_ill;
  logic             push;
  logic             pop;

  assign bus.in_ready  = (count != 2'd2) && !rst;
  assign bus.out_valid = (count != 2'd0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  // Once drained, the outputs keep showing the entry that left most recently.
  assign bus.out_imm     = bus.out_valid ? mem_imm[rd_ptr] : last_imm;
  assign bus.out_tag     = bus.out_valid ? mem_tag[rd_ptr] : last_tag;
  assign bus.out_illegal = bus.out_valid ? mem_ill[rd_ptr] : last_ill;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_imm[i] <= '0;
        mem_tag[i] <= '0;
        mem_ill[i] <= 1'b0;
      end
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      last_imm <= '0;
      last_tag <= '0;
      last_ill <= 1'b0;
    end else begin
      if (push) begin
        mem_imm[wr_ptr] <= imm_c;
        mem_tag[wr_ptr] <= bus.in_tag;
        mem_ill[wr_ptr] <= ill_c;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        last_imm <= mem_imm[rd_ptr];
        last_tag <= mem_tag[rd_ptr];
        last_ill <= mem_ill[rd_ptr];
        rd_ptr   <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - scoreboard testbench for imm_gen_pipe (XLEN 32 plus a shadow XLEN 64 instance)
module tb_imm_gen_pipe;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();
  imm_gen_pipe_if #(.XLEN(64),   .TAG_W(TAG_W)) bus64 ();

  assign bus64.in_valid  = bus.in_valid;
  assign bus64.in_inst   = bus.in_inst;
  assign bus64.in_sel    = bus.in_sel;
  assign bus64.in_tag    = bus.in_tag;
  assign bus64.out_ready = bus.out_ready;

  imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut   (.clk(clk), .rst(rst), .bus(bus));
  imm_gen_pipe #(.XLEN(64),   .TAG_W(TAG_W)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

  typedef struct {
    logic [63:0]      imm;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   passed = 0;
  int   pops = 0;
  bit   stream_done;

  function automatic logic [63:0] model_imm(input logic [31:0] i, input logic [2:0] s, input int xl);
    logic [63:0] r;
    case (s)
      3'd0: r = {{52{i[31]}}, i[31:20]};
      3'd1: r = {{52{i[31]}}, i[31:25], i[11:7]};
      3'd2: r = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3: r = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'd4: r = {{32{i[31]}}, i[31:12], 12'h000};
      3'd5: r = (xl == 32) ? {59'd0, i[24:20]} : {58'd0, i[25:20]};
`ifdef IMM_ZIMM_EN
      3'd6: r = {59'd0, i[19:15]};
`endif
      default: r = 64'd0;
    endcase
    if (xl == 32) r = {32'd0, r[31:0]};
    return r;
  endfunction

  function automatic logic model_ill(input logic [2:0] s);
`ifdef IMM_ZIMM_EN
    return s == 3'd7;
`else
    return s >= 3'd6;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        total++;
        pops++;
        if (sb.size() == 0) begin
          $display("FAIL sb_extra_output: got tag %0d imm %h, want no output pending", bus.out_tag, bus.out_imm);
        end else begin
          mon_e = sb.pop_front();
          if (bus.out_imm !== mon_e.imm[XLEN-1:0] || bus.out_tag !== mon_e.tag || bus.out_illegal !== mon_e.ill)
            $display("FAIL sb_output: got imm %h tag %0d ill %b, want imm %h tag %0d ill %b",
                     bus.out_imm, bus.out_tag, bus.out_illegal, mon_e.imm[XLEN-1:0], mon_e.tag, mon_e.ill);
          else
            passed++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        mon_e.imm = model_imm({bus.in_inst, 7'b0}, bus.in_sel, XLEN);
        mon_e.tag = bus.in_tag;
        mon_e.ill = model_ill(bus.in_sel);
        sb.push_back(mon_e);
      end
    end
  end

  task automatic send(input logic [31:0] inst, input logic [2:0] sel, input logic [TAG_W-1:0] tag);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_inst  = inst[31:7];
    bus.in_sel   = sel;
    bus.in_tag   = tag;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (ok) begin @(posedge clk); #1; end
    bus.in_valid = 1'b0;
    if (!ok) begin
      total++;
      $display("FAIL send_timeout: in_ready got 0 for 200 cycles, want 1 (tag %0d)", tag);
    end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!bus.out_valid) break;
    end
    total++;
    if (bus.out_valid !== 1'b0 || sb.size() != 0)
      $display("FAIL drain: out_valid got %b pending %0d, want 0 and 0", bus.out_valid, sb.size());
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); else passed++;
    total++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else passed++;
    total++;
    if ({bus.out_imm, bus.out_tag, bus.out_illegal} !== '0)
      $display("FAIL reset_out_fields: got imm %h tag %0d ill %b want all 0", bus.out_imm, bus.out_tag, bus.out_illegal);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_release_in_ready: got %b want 1", bus.in_ready); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_itype();
    bus.out_ready = 1'b1;
    send(32'hFFF0_0093, 3'd0, 5'd3);
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_imm !== 32'hFFFF_FFFF || bus.out_tag !== 5'd3 || bus.out_illegal !== 1'b0)
      $display("FAIL itype: got v %b imm %h tag %0d ill %b want v 1 imm ffffffff tag 3 ill 0",
               bus.out_valid, bus.out_imm, bus.out_tag, bus.out_illegal);
    else passed++;
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_bju();
    logic [31:0] insts [3] = '{32'hFE00_0EE3, 32'h0010_006F, 32'h1234_50B7};
    logic [2:0]  sels  [3] = '{3'd2, 3'd3, 3'd4};
    logic [31:0] e32   [3] = '{32'hFFFF_FFFC, 32'h0000_0800, 32'h1234_5000};
    logic [63:0] e64   [3] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_0000_0800, 64'h0000_0000_1234_5000};
    bus.out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      send(insts[n], sels[n], 5'(n + 10));
      @(negedge clk);
      total++;
      if (bus.out_imm !== e32[n] || bus.out_illegal !== 1'b0)
        $display("FAIL bju32_%0d: got imm %h ill %b want %h ill 0", n, bus.out_imm, bus.out_illegal, e32[n]);
      else passed++;
      total++;
      if (bus64.out_imm !== e64[n] || bus64.out_illegal !== 1'b0)
        $display("FAIL bju64_%0d: got imm %h ill %b want %h ill 0", n, bus64.out_imm, bus64.out_illegal, e64[n]);
      else passed++;
      @(posedge clk); #1;
    end
    drain();
  endtask

  task automatic test_reserved();
    logic [31:0] e6_imm;
    logic        e6_ill;
`ifdef IMM_ZIMM_EN
    e6_imm = 32'h0000_000F; e6_ill = 1'b0;
`else
    e6_imm = 32'h0; e6_ill = 1'b1;
`endif
    bus.out_ready = 1'b1;
    send(32'hFFFF_FFFF, 3'd7, 5'd9);
    @(negedge clk);
    total++;
    if (bus.out_illegal !== 1'b1 || bus.out_imm !== 32'h0 || bus.out_tag !== 5'd9)
      $display("FAIL reserved_111: got ill %b imm %h tag %0d want ill 1 imm 0 tag 9", bus.out_illegal, bus.out_imm, bus.out_tag);
    else passed++;
    @(posedge clk); #1;
    send(32'h0007_D073, 3'd6, 5'd8);
    @(negedge clk);
    total++;
    if (bus.out_illegal !== e6_ill || bus.out_imm !== e6_imm)
      $display("FAIL sel_110: got ill %b imm %h want ill %b imm %h", bus.out_illegal, bus.out_imm, e6_ill, e6_imm);
    else passed++;
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_backpressure();
    int p0 = pops;
    bit ok = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_sel    = 3'd1;
    for (int t = 1; t <= 2; t++) begin
      bus.in_tag  = 5'(t);
      bus.in_inst = 25'($urandom);
      @(negedge clk);
      total++;
      if (bus.in_ready !== 1'b1) $display("FAIL bp_accept_%0d: in_ready got %b want 1", t, bus.in_ready); else passed++;
      @(posedge clk); #1;
    end
    bus.in_tag  = 5'd3;
    bus.in_inst = 25'($urandom);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_tag !== 5'd1)
        $display("FAIL bp_stall_%0d: got in_ready %b out_valid %b out_tag %0d want 0 1 1",
                 k, bus.in_ready, bus.out_valid, bus.out_tag);
      else passed++;
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (ok) begin @(posedge clk); #1; end
    bus.in_valid = 1'b0;
    total++;
    if (!ok) $display("FAIL bp_resume: tag 3 got not accepted, want accepted"); else passed++;
    drain();
    total++;
    if (pops - p0 != 3) $display("FAIL bp_count: got %0d outputs want 3", pops - p0); else passed++;
  endtask

  task automatic test_reset_midflight();
    int p0;
    bus.out_ready = 1'b0;
    send(32'h8000_0013, 3'd0, 5'd4);
    send(32'h0040_0023, 3'd1, 5'd5);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b0) $display("FAIL midrst_in_ready: got %b want 0", bus.in_ready); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_imm !== 32'h0 || bus.in_ready !== 1'b1)
      $display("FAIL midrst_after: got out_valid %b imm %h in_ready %b want 0 0 1", bus.out_valid, bus.out_imm, bus.in_ready);
    else passed++;
    @(posedge clk); #1;
    p0 = pops;
    bus.out_ready = 1'b1;
    send(32'h1234_50B7, 3'd4, 5'd6);
    drain();
    total++;
    if (pops - p0 != 1) $display("FAIL midrst_new_only: got %0d outputs want 1", pops - p0); else passed++;
  endtask

  task automatic test_back_to_back();
    int p0 = pops;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int n = 0; n < 8; n++) begin
      bus.in_inst = 25'($urandom);
      bus.in_sel  = 3'($urandom_range(0, 5));
      bus.in_tag  = 5'(n);
      @(negedge clk);
      total++;
      if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready_%0d: got %b want 1", n, bus.in_ready); else passed++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    drain();
    total++;
    if (pops - p0 != 8) $display("FAIL b2b_count: got %0d outputs want 8", pops - p0); else passed++;
  endtask

  task automatic test_stream();
    int p0 = pops;
    int max_sel;
`ifdef IMM_ZIMM_EN
    max_sel = 6;
`else
    max_sel = 5;
`endif
    stream_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 100; n++)
          send($urandom, 3'($urandom_range(0, max_sel)), 5'(n));
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
    total++;
    if (pops - p0 != 100) $display("FAIL stream_count: got %0d outputs want 100", pops - p0); else passed++;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_inst   = '0;
    bus.in_sel    = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_itype();
    test_bju();
    test_reserved();
    test_backpressure();
    test_reset_midflight();
    test_back_to_back();
    test_stream();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation got no finish by 500000, want finish");
    $fatal(1);
  end
endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, flow-controlled immediate generator for the RV32I/RV64I decode stage. It extracts and sign- or zero-extends the immediate for every base instruction format and carries a side-band tag. Results are buffered in a 2-entry skid FIFO so downstream back-pressure never propagates combinationally upstream. It sits between instruction fetch/decode and the register-read/ALU operand mux, replacing the purely combinational immediate generator.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64; all sign extension fills to XLEN.
- TAG_W, 5, width of the pass-through tag (rd index, ROB id, etc.); minimum 1.

- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream holds a valid instruction.
- in_ready  output  1  block can accept; transfer when in_valid && in_ready.
- in_inst  input  25  instruction bits [31:7]; bits [6:0] are not needed.
- in_sel  input  3  format select (encoding under Operation).
- in_tag  input  TAG_W  side-band tag, returned unchanged.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
- out_imm  output  XLEN  extended immediate.
- out_tag  output  TAG_W  tag of the head entry.
- out_illegal  output  1  head entry used an unsupported in_sel.

## Operation
- Format select, with b = in_inst bit index:
  - 000 I: sext(b31:20).
  - 001 S: sext(b31:25, b11:7).
  - 010 B: sext(b31, b7, b30:25, b11:8, 0).
  - 011 J: sext(b31, b19:12, b20, b30:21, 0).
  - 100 U: sext(b31:12, 12'b0). For XLEN=32 no extension occurs.
  - 101 SHAMT: zext(b24:20) when XLEN=32; zext(b25:20) when XLEN=64.
  - 110 ZIMM: available only with the macro (see Configuration).
  - 111: reserved.
- Illegal selects:
  - Reserved selects set out_illegal=1 and out_imm=0; the entry is still queued and flows normally.
  - For a legal select, out_illegal=0.
- Immediate computation happens combinationally on the input side. The result {imm, tag, illegal} is written into the FIFO on acceptance.
- FIFO:
  - 2 entries, with a write pointer, read pointer and 2-bit count.
  - Writes and reads wrap modulo 2.
  - Push condition: in_valid && in_ready. Pop condition: out_valid && out_ready.
- in_ready = (count != 2) && !rst. It depends only on registered state, with no combinational path from out_ready.
- out_valid = (count != 0). The out_* data fields always present the head entry.
- When the FIFO is empty, out_imm, out_tag and out_illegal retain the last popped values.
- Simultaneous push and pop at count 1: count stays 1, the head advances, and the new entry becomes the head next cycle.
- Pop at count 2 with no push (in_ready=0): count becomes 1, and in_ready=1 in the following cycle.
- Push at count 0 and pop at count 0 cannot coincide, because out_valid=0.
- When out_valid && !out_ready, out_imm, out_tag and out_illegal must hold stable.

## Timing
- Reset (synchronous, any cycle, including mid-transfer):
  - count=0, pointers=0, out_valid=0, out_imm=0, out_tag=0, out_illegal=0.
  - in_ready=0 while rst is high and 1 on the first cycle after.
  - In-flight entries are discarded.
- Latency: an instruction accepted at edge N appears with out_valid=1 after edge N, i.e. 1 cycle when the FIFO is empty.
- Throughput: 1 instruction per cycle sustained while out_ready=1.
- Back-pressure: with out_ready=0, exactly 2 instructions are accepted. in_ready then falls in the cycle after the second acceptance.

## Configuration
- IMM_ZIMM_EN defined: select 110 returns zext(b19:15), the CSRRWI/CSRRSI/CSRRCI uimm, with out_illegal=0.
- IMM_ZIMM_EN undefined: select 110 is treated as reserved, giving out_illegal=1 and out_imm=0.

## Test plan
- I-type: XLEN=32, in_inst=0xFFF00093>>7, sel=000, tag=3, out_ready=1 -> one cycle later out_imm=0xFFFFFFFF, out_tag=3, out_illegal=0.
- B, J and U types:
  - B: inst 0xFE000EE3, sel=010 -> 0xFFFFFFFC.
  - J: inst 0x0010006F, sel=011 -> 0x00000800.
  - U: inst 0x123450B7, sel=100 -> 0x12345000.
  - With XLEN=64, the B case gives 0xFFFFFFFFFFFFFFFC.
- Back-pressure: out_ready=0 while pushing tags 1, 2 and 3 back to back -> tags 1 and 2 are accepted, in_ready=0, and out_tag stays 1 while stalled. Then out_ready=1 -> tags 1, 2, 3 emerge in order, and the FIFO is empty afterward.
- Reserved select: sel=111 -> out_illegal=1 and out_imm=0. sel=110 -> out_illegal=1 without IMM_ZIMM_EN; with it, inst 0x0007D073 gives out_imm=0x0000000F.
- Reset: with 2 entries buffered, assert rst for 1 cycle -> out_valid=0, out_imm=0, in_ready=0 during reset and 1 afterward. A new push then returns only the new entry.
- Streaming: 100 random legal instructions with random out_ready -> in-order outputs that match a reference model, with no drops and no duplicates.
